// File: rtl/conv2_accumulate_if.sv
// Bus between the layer-2 multiplier stage and the layer-2 accumulator stage.
// The multiplier side drives a product group; the accumulator side returns the pixel.
interface conv2_accumulate_if;
    logic               in_valid;
    logic signed [15:0] product1;
    logic signed [15:0] product2;
    logic signed [15:0] product3;
    logic signed [15:0] product4;
    logic signed [15:0] product5;
    logic signed [15:0] product6;
    logic signed [7:0]  data_out;
    logic               out_valid;
    logic               busy;

    modport master (
        output in_valid, product1, product2, product3, product4, product5, product6,
        input  data_out, out_valid, busy
    );

    modport slave (
        input  in_valid, product1, product2, product3, product4, product5, product6,
        output data_out, out_valid, busy
    );
endinterface

// File: rtl/conv2_accumulate.sv
// Conv layer 2 adder/accumulator: sums six products per group, accumulates NUM_GROUPS
// groups into one pixel, then requantizes to signed 8 bits (shift, optional ReLU, clamp).
module conv2_accumulate #(
    parameter int NUM_GROUPS = 4,
    parameter int SHIFT      = 6,
    parameter bit RELU       = 1'b1
) (
    input logic               clk,
    input logic               reset,
    conv2_accumulate_if.slave bus
);

    localparam int CW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    logic               v0;
    logic signed [16:0] pair_a, pair_b, pair_c;
    logic               v1;
    logic signed [18:0] group_sum;
    logic signed [23:0] acc;
    logic [CW-1:0]      grp_cnt;
    logic signed [7:0]  data_q;
    logic               valid_q;

    logic signed [23:0] final_sum;
    logic signed [23:0] shifted;
    logic signed [7:0]  requant;
    logic               last_group;

    // E0: pair sums. Products are only captured on a valid group.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values; a blocking write here would leak into later stages in the same edge.
        if (reset) begin
            v0     <= 1'b0;
            pair_a <= '0;
            pair_b <= '0;
            pair_c <= '0;
        end else begin
            v0 <= bus.in_valid;
            if (bus.in_valid) begin
                pair_a <= 17'(bus.product1) + 17'(bus.product2);
                pair_b <= 17'(bus.product3) + 17'(bus.product4);
                pair_c <= 17'(bus.product5) + 17'(bus.product6);
            end
        end
    end

    // E1: group sum
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            group_sum <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                group_sum <= 19'(pair_a) + 19'(pair_b) + 19'(pair_c);
            end
        end
    end

    // The first group of a pixel replaces the accumulator, so back-to-back pixels never mix.
    assign final_sum  = (grp_cnt == '0) ? 24'(group_sum) : acc + 24'(group_sum);
    assign last_group = (grp_cnt == CW'(NUM_GROUPS - 1));
    assign shifted    = final_sum >>> SHIFT;

    always_comb begin
        // NOTE: default assigned first so every path drives requant and no latch is inferred.
        requant = shifted[7:0];
        if (RELU && shifted < 0) begin
            requant = '0;
        end else if (shifted > 24'sd127) begin
            requant = 8'sd127;
        end else if (shifted < -24'sd128) begin
            requant = -8'sd128;
        end
    end

    // E2: accumulate, and on the last group publish the requantized pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            grp_cnt <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (v1) begin
                acc <= final_sum;
                if (last_group) begin
                    grp_cnt <= '0;
                    data_q  <= requant;
                    valid_q <= 1'b1;
                end else begin
                    grp_cnt <= grp_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (grp_cnt != '0) || v0 || v1;

endmodule
